// File: rtl/frame_painter_pkg.sv
// frame_painter_pkg: FSM encoding, default screen geometry and width
// helpers shared by frame_painter and brush_scanner.
package frame_painter_pkg;

    localparam int DEF_COL_NUM = 320;
    localparam int DEF_ROW_NUM = 240;

    localparam logic [2:0] ST_RESET      = 3'd0;
    localparam logic [2:0] ST_IDLE       = 3'd1;
    localparam logic [2:0] ST_LOAD_FETCH = 3'd2;
    localparam logic [2:0] ST_LOAD_WRITE = 3'd3;
    localparam logic [2:0] ST_CLEAR      = 3'd4;
    localparam logic [2:0] ST_PAINT      = 3'd5;

    // clog2 with a floor of one bit so single-entry ranges still get a port
    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_painter_brush_scanner.sv
// brush_scanner: walks the (2R+1)^2 brush offsets row-major around a
// latched centre and flags offsets that fall outside the screen.
module brush_scanner
    import frame_painter_pkg::*;
#(
    parameter int COL_NUM = DEF_COL_NUM,
    parameter int ROW_NUM = DEF_ROW_NUM,
    parameter int COL_W   = 9,
    parameter int ROW_W   = 8,
    parameter int BR_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             accept_i,
    input  logic [COL_W-1:0] ctr_col_i,
    input  logic [ROW_W-1:0] ctr_row_i,
    input  logic [BR_W-1:0]  radius_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             in_bounds_o,
    output logic             last_o
);

    localparam int OFF_W = BR_W + 1;
    localparam int SC_W  = COL_W + 2;
    localparam int SR_W  = ROW_W + 2;

    logic [COL_W-1:0] cc_q;
    logic [ROW_W-1:0] cr_q;
    logic [OFF_W-1:0] r_q;
    logic [OFF_W-1:0] dx_q;
    logic [OFF_W-1:0] dy_q;
    logic [SC_W-1:0]  sc;
    logic [SR_W-1:0]  sr;
    logic             col_ok;
    logic             row_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cc_q <= '0;
            cr_q <= '0;
            r_q  <= '0;
            dx_q <= '0;
            dy_q <= '0;
        end else if (start_i) begin
            cc_q <= ctr_col_i;
            cr_q <= ctr_row_i;
            r_q  <= {1'b0, radius_i};
            dx_q <= -{1'b0, radius_i};
            dy_q <= -{1'b0, radius_i};
        end else if (accept_i) begin
            if (dx_q == r_q) begin
                dx_q <= -r_q;
                dy_q <= dy_q + OFF_W'(1);
            end else begin
                dx_q <= dx_q + OFF_W'(1);
            end
        end
    end

    // offsets are two's complement; the extra bits keep the sign of the sum
    assign sc = {2'b00, cc_q} + {{(SC_W-OFF_W){dx_q[OFF_W-1]}}, dx_q};
    assign sr = {2'b00, cr_q} + {{(SR_W-OFF_W){dy_q[OFF_W-1]}}, dy_q};

    assign col_ok = !sc[SC_W-1] && (sc < SC_W'(COL_NUM));
    assign row_ok = !sr[SR_W-1] && (sr < SR_W'(ROW_NUM));

    assign col_o       = sc[COL_W-1:0];
    assign row_o       = sr[ROW_W-1:0];
    assign in_bounds_o = col_ok && row_ok;
    assign last_o      = (dx_q == r_q) && (dy_q == r_q);

endmodule

// File: rtl/frame_painter.sv
// frame_painter: ROM frame loader, screen clear and square-brush painter.
// Define FRAME_PAINTER_PIXCNT_EN to add the painted_count output.
module frame_painter
    import frame_painter_pkg::*;
#(
    parameter int N_FRAMES    = 2,
    parameter int COL_NUM     = DEF_COL_NUM,
    parameter int ROW_NUM     = DEF_ROW_NUM,
    parameter int COLOR_WIDTH = 1,
    parameter int ADC_WIDTH   = 12,
    parameter int BRUSH_R_MAX = 3,
    localparam int PIXEL_NUM  = COL_NUM * ROW_NUM,
    localparam int COL_W      = width_of(COL_NUM),
    localparam int ROW_W      = width_of(ROW_NUM),
    localparam int FSEL_W     = width_of(N_FRAMES),
    localparam int BR_W       = width_of(BRUSH_R_MAX + 1),
    localparam int ROM_AW     = width_of(PIXEL_NUM * N_FRAMES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [FSEL_W-1:0]      load_frame_sel,
    input  logic                   clear_req,
    input  logic [COLOR_WIDTH-1:0] brush_color,
    input  logic [COLOR_WIDTH-1:0] bg_color,
    input  logic [BR_W-1:0]        brush_r,
    output logic [ROM_AW-1:0]      rom_addr,
    input  logic [COLOR_WIDTH-1:0] rom_q,
    input  logic                   initialized,
    output logic                   pixel_valid,
    input  logic                   pixel_ready,
    output logic [COL_W-1:0]       pixel_col,
    output logic [ROW_W-1:0]       pixel_row,
    output logic [COLOR_WIDTH-1:0] pixel_color,
    input  logic                   pos_ready,
    input  logic [ADC_WIDTH-1:0]   x_pos,
    input  logic [ADC_WIDTH-1:0]   y_pos,
    output logic                   busy
`ifdef FRAME_PAINTER_PIXCNT_EN
    ,
    output logic [width_of(PIXEL_NUM+1)-1:0] painted_count
`endif
);

    localparam int PTR_W = width_of(PIXEL_NUM);
    localparam int XP_W  = ADC_WIDTH + COL_W;
    localparam int YP_W  = ADC_WIDTH + ROW_W;
    localparam logic [BR_W-1:0] R_MAX = BR_W'(BRUSH_R_MAX);

    logic [2:0]        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [FSEL_W-1:0] frame_q, frame_d;
    logic              clr_pend_q, clr_pend_d;
    logic              tch_pend_q;
    logic [COL_W-1:0]  tch_col_q;
    logic [ROW_W-1:0]  tch_row_q;

    logic [COL_W-1:0]  x_col;
    logic [ROW_W-1:0]  y_row;
    logic [BR_W-1:0]   r_sat;
    logic              last_pix;
    logic              clr_take;
    logic              sc_start;
    logic              sc_adv;
    logic [COL_W-1:0]  sc_col;
    logic [ROW_W-1:0]  sc_row;
    logic              sc_in;
    logic              sc_last;

    assign x_col = COL_W'((XP_W'(x_pos) * XP_W'(COL_NUM)) >> ADC_WIDTH);
    assign y_row = ROW_W'((YP_W'(y_pos) * YP_W'(ROW_NUM)) >> ADC_WIDTH);
    assign r_sat = (brush_r > R_MAX) ? R_MAX : brush_r;

    assign last_pix = (ptr_q == PTR_W'(PIXEL_NUM - 1));
    // clipped offsets advance unconditionally, drawable ones wait for ready
    assign sc_adv   = (state_q == ST_PAINT) && (!sc_in || pixel_ready);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        col_d    = col_q;
        row_d    = row_q;
        frame_d  = frame_q;
        clr_take = 1'b0;
        sc_start = 1'b0;
        unique case (state_q)
            ST_RESET: begin
                if (initialized) begin
                    state_d = ST_LOAD_FETCH;
                    frame_d = load_frame_sel;
                end
            end
            ST_IDLE: begin
                if (en) begin
                    if (clr_pend_q || clear_req) begin
                        state_d  = ST_CLEAR;
                        clr_take = 1'b1;
                    end else if (load_frame_sel != frame_q) begin
                        state_d = ST_LOAD_FETCH;
                        frame_d = load_frame_sel;
                    end else if (tch_pend_q) begin
                        state_d  = ST_PAINT;
                        sc_start = 1'b1;
                    end
                end
            end
            ST_LOAD_FETCH: state_d = ST_LOAD_WRITE;
            ST_LOAD_WRITE, ST_CLEAR: begin
                if (pixel_ready) begin
                    if (last_pix) begin
                        state_d = ST_IDLE;
                        ptr_d   = '0;
                        col_d   = '0;
                        row_d   = '0;
                    end else begin
                        state_d = (state_q == ST_CLEAR) ? ST_CLEAR
                                                        : ST_LOAD_FETCH;
                        ptr_d   = ptr_q + PTR_W'(1);
                        if (col_q == COL_W'(COL_NUM - 1)) begin
                            col_d = '0;
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
            end
            ST_PAINT: begin
                if (sc_adv && sc_last) state_d = ST_IDLE;
            end
            default: state_d = ST_RESET;
        endcase
    end

    assign clr_pend_d = !clr_take && (clr_pend_q || clear_req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            ptr_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            frame_q    <= '0;
            clr_pend_q <= 1'b0;
            tch_pend_q <= 1'b0;
            tch_col_q  <= '0;
            tch_row_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            frame_q    <= frame_d;
            clr_pend_q <= clr_pend_d;
            if (pos_ready) begin
                tch_pend_q <= 1'b1;
                tch_col_q  <= x_col;
                tch_row_q  <= y_row;
            end else if (sc_start) begin
                tch_pend_q <= 1'b0;
            end
        end
    end

    brush_scanner #(
        .COL_NUM (COL_NUM),
        .ROW_NUM (ROW_NUM),
        .COL_W   (COL_W),
        .ROW_W   (ROW_W),
        .BR_W    (BR_W)
    ) u_scan (
        .clk         (clk),
        .reset       (reset),
        .start_i     (sc_start),
        .accept_i    (sc_adv),
        .ctr_col_i   (tch_col_q),
        .ctr_row_i   (tch_row_q),
        .radius_i    (r_sat),
        .col_o       (sc_col),
        .row_o       (sc_row),
        .in_bounds_o (sc_in),
        .last_o      (sc_last)
    );

    always_comb begin
        pixel_valid = 1'b0;
        pixel_color = '0;
        unique case (state_q)
            ST_LOAD_WRITE: begin
                pixel_valid = 1'b1;
                pixel_color = rom_q;
            end
            ST_CLEAR: begin
                pixel_valid = 1'b1;
                pixel_color = bg_color;
            end
            ST_PAINT: begin
                pixel_valid = sc_in;
                pixel_color = brush_color;
            end
            default: ;
        endcase
    end

    assign pixel_col = (state_q == ST_PAINT) ? sc_col : col_q;
    assign pixel_row = (state_q == ST_PAINT) ? sc_row : row_q;
    assign rom_addr  = ROM_AW'(frame_q) * ROM_AW'(PIXEL_NUM) + ROM_AW'(ptr_q);
    assign busy      = (state_q != ST_IDLE);

`ifdef FRAME_PAINTER_PIXCNT_EN
    localparam int CNT_W = width_of(PIXEL_NUM + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             fill_done;
    logic             paint_acc;

    assign fill_done = ((state_q == ST_LOAD_WRITE) || (state_q == ST_CLEAR))
                       && pixel_ready && last_pix;
    assign paint_acc = (state_q == ST_PAINT) && sc_in && pixel_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (fill_done) begin
            cnt_q <= '0;
        end else if (paint_acc && (cnt_q != CNT_W'(PIXEL_NUM))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign painted_count = cnt_q;
`endif

endmodule

// File: doc/frame_painter.md
Name: frame_painter

Overview:
- Parametrised successor to the single-pixel B/W painter. Sits between the touchscreen driver, the frame ROM and the graphic manager.
- Loads constant frames from ROM into LCD frame RAM. Clears the screen to a background colour. Paints touch points with a square brush of runtime-selectable radius.
- Multi-bit colour, parametrised screen and ADC geometry, edge clipping, and a ready/valid pixel handshake with back-pressure.

Parameters:
- N_FRAMES, 2, number of pre-loaded ROM frames
- COL_NUM, 320, screen columns
- ROW_NUM, 240, screen rows
- COLOR_WIDTH, 1, bits per pixel colour, also the ROM data width
- ADC_WIDTH, 12, touch coordinate resolution
- BRUSH_R_MAX, 3, maximum brush radius; brush side = 2r+1
- Derived: PIXEL_NUM = COL_NUM*ROW_NUM; COL_W = clog2(COL_NUM); ROW_W = clog2(ROW_NUM); FSEL_W = clog2(N_FRAMES), min 1; BR_W = clog2(BRUSH_R_MAX+1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  enables new paint/load/clear requests
- load_frame_sel  in  FSEL_W  frame selector; a change while en=1 requests a load
- clear_req  in  1  single-cycle pulse; requests fill with bg_color
- brush_color  in  COLOR_WIDTH  paint colour
- bg_color  in  COLOR_WIDTH  clear colour
- brush_r  in  BR_W  brush radius; values above BRUSH_R_MAX saturate
- rom_addr  out  clog2(PIXEL_NUM*N_FRAMES)  frame ROM address = frame*PIXEL_NUM + pointer
- rom_q  in  COLOR_WIDTH  ROM data; synchronous read, 1-cycle latency
- initialized  in  1  graphic manager ready after power-up
- pixel_valid  out  1  pixel write request
- pixel_ready  in  1  graphic manager accepts the write when pixel_valid && pixel_ready
- pixel_col  out  COL_W  write column
- pixel_row  out  ROW_W  write row
- pixel_color  out  COLOR_WIDTH  write colour
- pos_ready  in  1  touch sample strobe
- x_pos, y_pos  in  ADC_WIDTH  raw touch coordinates
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async): state RESET. All outputs 0. Pointer, brush offsets, pending-touch register and frame register cleared. busy=1 in RESET.
- RESET -> LOAD_FETCH when initialized=1. The first load uses load_frame_sel sampled at that cycle; no en required.
- IDLE, evaluated only when en=1, in priority order:
  - clear pending -> CLEAR
  - load_frame_sel != registered frame -> LOAD_FETCH; the register is updated on entry
  - touch pending -> PAINT
  - en=0: requests stay pending.
- clear_req latches a pending flag in any state. The flag clears on entry to CLEAR.
- pos_ready in any state captures the scaled coordinates into a 1-deep pending buffer; a newer sample overwrites an older one. Scaling: col = (x_pos*COL_NUM)>>ADC_WIDTH, row = (y_pos*ROW_NUM)>>ADC_WIDTH, with full-width products. Result is always < COL_NUM and < ROW_NUM.
- LOAD_FETCH: drives rom_addr for the current pointer; pixel_valid=0. Next state LOAD_WRITE.
- LOAD_WRITE:
  - pixel_valid=1, pixel_color=rom_q; col/row are pointer mod/div COL_NUM, kept as incremental col/row counters with no divider.
  - rom_addr, col, row and colour stay stable until the write is accepted.
  - On accept: pointer increments and the state returns to LOAD_FETCH; on the accept at pointer = PIXEL_NUM-1 the state goes to IDLE instead.
- CLEAR: pixel_valid=1 with pixel_color=bg_color. Walks all pixels at 1 pixel per accepted cycle; last accept -> IDLE.
- PAINT:
  - Latches the pending touch centre (c,r) and the saturated radius R on entry.
  - Scans offsets dy = -R..R (outer) and dx = -R..R (inner); pixel_color = brush_color.
  - Clipping: offsets with c+dx or r+dy outside the screen are skipped with pixel_valid=0 and cost one cycle each. The screen edge is never wrapped.
  - The last offset, accepted or skipped -> IDLE.
  - R=0 gives a single write.
- pixel_valid never drops without an accept, except on reset.
- No mid-operation abort: a touch arriving during LOAD/CLEAR/PAINT waits in the buffer; a frame change is re-evaluated in IDLE.
- Reset mid-operation: immediate return to RESET, then a full reload of the frame sampled at initialized.

Optional Feature:
- FRAME_PAINTER_PIXCNT_EN defined:
  - Adds output painted_count [clog2(PIXEL_NUM+1)-1:0], counting accepted PAINT writes and saturating at PIXEL_NUM.
  - Zeroed by reset and at completion of any LOAD or CLEAR. Used to reject empty digit submissions.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package frame_painter_pkg holds:
  - state encoding RESET, IDLE, LOAD_FETCH, LOAD_WRITE, CLEAR, PAINT
  - derived width functions
  - default screen constants 320/240
- Sub-module brush_scanner: offset generator with clip logic. Inputs centre, radius, accept, start. Outputs col, row, in_bounds, last. Shared by PAINT only.

Test Plan:
- Reset, then initialized=1 with load_frame_sel=1 -> exactly 76800 accepted writes; the first uses rom_addr 76800, the last has col 319, row 239; busy falls after the last accept.
- pos_ready with x=2048, y=2048, brush_r=1, pixel_ready=1 -> 9 writes at col 159..161, row 119..121 in row-major order, colour = brush_color.
- x=0, y=0, brush_r=2 -> only the 9 writes with col,row in 0..2; 16 clipped cycles with pixel_valid=0; no wrap to col 319.
- pixel_ready toggled randomly during LOAD -> row/col/colour stable while stalled; ROM image reproduced bit-exact in the RAM model.
- clear_req, load_frame_sel change and pos_ready all in the same IDLE cycle -> CLEAR runs first, then LOAD, then a single PAINT.
- Reset asserted mid-PAINT -> all outputs 0 asynchronously; after release and initialized, a full reload occurs and the pending touch is discarded.
